// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the data-memory read-port arbiter: slot state codes
// and the address/data word width.
`ifndef MEM_PORT_ARBITER_PKG_SV
`define MEM_PORT_ARBITER_PKG_SV

`define SLOT_IDLE 2'd0
`define SLOT_PEND 2'd1
`define SLOT_WAIT 2'd2

package mem_port_arbiter_pkg;
  localparam int AW = 16;
  typedef logic [AW-1:0] word_t;
endpackage

`endif

// File: rtl/rr_pick.sv
// Round-robin picker: first set bit of req scanning upward from start, wrapping
// modulo N. Purely combinational.
module rr_pick #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] start,
  output logic          found,
  output logic [PW-1:0] idx
);
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && req[(int'(start) + k) % N]) begin
        found = 1'b1;
        idx   = PW'((int'(start) + k) % N);
      end
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory read port among NREQ single-outstanding requesters:
// round-robin issue, capped in-flight count, responses routed by address.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int MAX_OUT = 4,
  parameter int CW      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req_re,
  input  logic [AW*NREQ-1:0] req_addr,
  output logic [NREQ-1:0]  req_busy,
  output logic [NREQ-1:0]  rsp_valid,
  output logic [AW-1:0]    rsp_data,
  output logic             mem_re,
  output logic [AW-1:0]    mem_raddr,
  input  logic             mem_ready,
  input  logic [AW-1:0]    mem_addr_out,
  input  logic [AW-1:0]    mem_data_out
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0][1:0] st_q, st_d;
  word_t [NREQ-1:0]     addr_q, addr_d;
  logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]        out_cnt_q, out_cnt_d;
  logic                 mem_re_q, mem_re_d;
  word_t                mem_raddr_q, mem_raddr_d;
  logic [NREQ-1:0]      rsp_valid_q, rsp_valid_d;
  word_t                rsp_data_q, rsp_data_d;

  logic [NREQ-1:0] pend;
  logic            found;
  logic [PW-1:0]   win;
  logic            issue;

  always_comb begin
    pend     = '0;
    req_busy = '0;
    for (int i = 0; i < NREQ; i++) begin
      pend[i]     = (st_q[i] == `SLOT_PEND);
      req_busy[i] = (st_q[i] != `SLOT_IDLE);
    end
  end

  rr_pick #(.N(NREQ), .PW(PW)) u_pick (
    .req   (pend),
    .start (rr_ptr_q),
    .found (found),
    .idx   (win)
  );

  assign issue = found && (out_cnt_q < CW'(MAX_OUT));

  // Accept, issue and response touch disjoint slot states (IDLE/PEND/WAIT),
  // so all three can be applied to the same next-state without conflict.
  always_comb begin
    st_d        = st_q;
    addr_d      = addr_q;
    rr_ptr_d    = rr_ptr_q;
    out_cnt_d   = out_cnt_q;
    mem_re_d    = issue;
    mem_raddr_d = mem_raddr_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    for (int i = 0; i < NREQ; i++) begin
      if (st_q[i] == `SLOT_IDLE && req_re[i]) begin
        st_d[i]   = `SLOT_PEND;
        addr_d[i] = req_addr[AW*i +: AW];
      end
      if (mem_ready && st_q[i] == `SLOT_WAIT && addr_q[i] == mem_addr_out) begin
        st_d[i]        = `SLOT_IDLE;
        rsp_valid_d[i] = 1'b1;
        rsp_data_d     = mem_data_out;
      end
    end
    if (issue) begin
      st_d[win]   = `SLOT_WAIT;
      mem_raddr_d = addr_q[win];
      rr_ptr_d    = (int'(win) == NREQ - 1) ? '0 : win + PW'(1);
    end
    // Unmatched responses still retire a memory read; floor at zero after reset.
    if (issue && !mem_ready)
      out_cnt_d = out_cnt_q + CW'(1);
    else if (!issue && mem_ready && out_cnt_q != '0)
      out_cnt_d = out_cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= '0;
      addr_q      <= '0;
      rr_ptr_q    <= '0;
      out_cnt_q   <= '0;
      mem_re_q    <= 1'b0;
      mem_raddr_q <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      st_q        <= st_d;
      addr_q      <= addr_d;
      rr_ptr_q    <= rr_ptr_d;
      out_cnt_q   <= out_cnt_d;
      mem_re_q    <= mem_re_d;
      mem_raddr_q <= mem_raddr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign mem_re    = mem_re_q;
  assign mem_raddr = mem_raddr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, directed corner sequences and a
// randomized run against a slot-level reference model.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_re;
  logic [31:0] req_addr;
  logic [1:0]  req_busy, rsp_valid;
  logic [15:0] rsp_data, mem_raddr, mem_addr_out, mem_data_out;
  logic        mem_re, mem_ready;

  logic [2:0]  c_req_re, c_busy, c_rv;
  logic [47:0] c_req_addr;
  logic [15:0] c_rdata, c_raddr, c_maddr, c_mdata;
  logic        c_mre, c_rdy;

  always #5 clk = ~clk;

  mem_port_arbiter #(.NREQ(2), .MAX_OUT(4), .CW(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_re(req_re), .req_addr(req_addr),
    .req_busy(req_busy), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_ready(mem_ready),
    .mem_addr_out(mem_addr_out), .mem_data_out(mem_data_out)
  );

  mem_port_arbiter #(.NREQ(3), .MAX_OUT(2), .CW(4)) u_cap (
    .clk(clk), .rst_n(rst_n), .req_re(c_req_re), .req_addr(c_req_addr),
    .req_busy(c_busy), .rsp_valid(c_rv), .rsp_data(c_rdata),
    .mem_re(c_mre), .mem_raddr(c_raddr), .mem_ready(c_rdy),
    .mem_addr_out(c_maddr), .mem_data_out(c_mdata)
  );

  int n_chk = 0, n_pass = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  typedef struct {
    logic [1:0]  re;
    logic [15:0] a0, a1;
    logic        rdy;
    logic [15:0] ma, md;
    logic [1:0]  busy;
    logic        mre;
    logic [15:0] raddr;
    logic [1:0]  rv;
    logic [15:0] rdata;
  } vec_t;

  function automatic vec_t mk(logic [1:0] re, logic [15:0] a0, logic [15:0] a1,
                              logic rdy, logic [15:0] ma, logic [15:0] md,
                              logic [1:0] busy, logic mre, logic [15:0] raddr,
                              logic [1:0] rv, logic [15:0] rdata);
    vec_t v;
    v.re = re; v.a0 = a0; v.a1 = a1; v.rdy = rdy; v.ma = ma; v.md = md;
    v.busy = busy; v.mre = mre; v.raddr = raddr; v.rv = rv; v.rdata = rdata;
    return v;
  endfunction

  task automatic clr_inputs;
    req_re = '0; req_addr = '0; mem_ready = 1'b0; mem_addr_out = '0; mem_data_out = '0;
    c_req_re = '0; c_req_addr = '0; c_rdy = 1'b0; c_maddr = '0; c_mdata = '0;
  endtask

  task automatic do_reset;
    clr_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference model: slot status 0=idle 1=pending 2=waiting, plus port regs.
  int          m_st[2];
  logic [15:0] m_addr[2];
  int          m_rr, m_cnt;
  logic        m_re;
  logic [15:0] m_raddr, m_rdata;
  logic [1:0]  m_rv;

  task automatic model_reset;
    m_st = '{0, 0}; m_addr = '{16'h0, 16'h0};
    m_rr = 0; m_cnt = 0; m_re = 0; m_raddr = 0; m_rdata = 0; m_rv = 0;
  endtask

  task automatic model_step(input logic [1:0] rq, input logic [15:0] a0, input logic [15:0] a1,
                            input logic rdy, input logic [15:0] ma, input logic [15:0] md);
    int nst[2];
    logic [15:0] na[2];
    int w;
    bit iss;
    w = -1;
    for (int k = 0; k < 2; k++)
      if (w < 0 && m_st[(m_rr + k) % 2] == 1) w = (m_rr + k) % 2;
    iss = (w >= 0) && (m_cnt < 4);
    m_rv = '0;
    for (int i = 0; i < 2; i++) begin
      nst[i] = m_st[i]; na[i] = m_addr[i];
      if (m_st[i] == 0 && rq[i]) begin nst[i] = 1; na[i] = (i == 1) ? a1 : a0; end
      if (iss && w == i) nst[i] = 2;
      if (rdy && m_st[i] == 2 && m_addr[i] == ma) begin nst[i] = 0; m_rv[i] = 1'b1; end
    end
    if (m_rv != 0) m_rdata = md;
    m_re = iss;
    if (iss) begin m_raddr = m_addr[w]; m_rr = (w + 1) % 2; end
    if (iss && !rdy) m_cnt++;
    else if (!iss && rdy && m_cnt > 0) m_cnt--;
    m_st = nst; m_addr = na;
  endtask

  vec_t tbl[15];
  logic [15:0] memq[$];

  initial begin
    tbl[0]  = mk(2'b01, 16'h0010, 16'h0000, 0, 16'h0, 16'h0,    2'b01, 0, 16'h0000, 2'b00, 16'h0000);
    tbl[1]  = mk(2'b00, 16'h0000, 16'h0000, 0, 16'h0, 16'h0,    2'b01, 1, 16'h0010, 2'b00, 16'h0000);
    tbl[2]  = mk(2'b00, 16'h0000, 16'h0000, 0, 16'h0, 16'h0,    2'b01, 0, 16'h0010, 2'b00, 16'h0000);
    tbl[3]  = mk(2'b00, 16'h0000, 16'h0000, 1, 16'h0010, 16'hBEEF, 2'b00, 0, 16'h0010, 2'b01, 16'hBEEF);
    tbl[4]  = mk(2'b00, 16'h0000, 16'h0000, 0, 16'h0, 16'h0,    2'b00, 0, 16'h0010, 2'b00, 16'hBEEF);
    tbl[5]  = mk(2'b10, 16'h0000, 16'h0300, 0, 16'h0, 16'h0,    2'b10, 0, 16'h0010, 2'b00, 16'hBEEF);
    tbl[6]  = mk(2'b00, 16'h0000, 16'h0000, 0, 16'h0, 16'h0,    2'b10, 1, 16'h0300, 2'b00, 16'hBEEF);
    tbl[7]  = mk(2'b10, 16'h0000, 16'h0555, 0, 16'h0, 16'h0,    2'b10, 0, 16'h0300, 2'b00, 16'hBEEF);
    tbl[8]  = mk(2'b00, 16'h0000, 16'h0000, 0, 16'h0, 16'h0,    2'b10, 0, 16'h0300, 2'b00, 16'hBEEF);
    tbl[9]  = mk(2'b00, 16'h0000, 16'h0000, 1, 16'h0300, 16'hCAFE, 2'b00, 0, 16'h0300, 2'b10, 16'hCAFE);
    tbl[10] = mk(2'b11, 16'h0042, 16'h0042, 0, 16'h0, 16'h0,    2'b11, 0, 16'h0300, 2'b00, 16'hCAFE);
    tbl[11] = mk(2'b00, 16'h0000, 16'h0000, 0, 16'h0, 16'h0,    2'b11, 1, 16'h0042, 2'b00, 16'hCAFE);
    tbl[12] = mk(2'b00, 16'h0000, 16'h0000, 0, 16'h0, 16'h0,    2'b11, 1, 16'h0042, 2'b00, 16'hCAFE);
    tbl[13] = mk(2'b00, 16'h0000, 16'h0000, 1, 16'h0042, 16'h1234, 2'b00, 0, 16'h0042, 2'b11, 16'h1234);
    tbl[14] = mk(2'b00, 16'h0000, 16'h0000, 1, 16'h0042, 16'h5678, 2'b00, 0, 16'h0042, 2'b00, 16'h1234);

    // Reset state, checked while rst_n is still low.
    clr_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {req_busy, mem_re, mem_raddr, rsp_valid, rsp_data, c_busy, c_mre}, 64'h0);
    rst_n = 1'b1;

    // Vector table: single request, busy drop, shared address.
    for (int i = 0; i < 15; i++) begin
      req_re = tbl[i].re; req_addr = {tbl[i].a1, tbl[i].a0};
      mem_ready = tbl[i].rdy; mem_addr_out = tbl[i].ma; mem_data_out = tbl[i].md;
      tick();
      check($sformatf("vec%0d", i), {req_busy, mem_re, mem_raddr, rsp_valid, rsp_data},
            {tbl[i].busy, tbl[i].mre, tbl[i].raddr, tbl[i].rv, tbl[i].rdata});
    end
    clr_inputs();
    check("out_cnt_drained", u_dut.out_cnt_q, 4'd0);

    // Round-robin: both requesters re-request at once, memory answers next cycle.
    do_reset();
    begin
      int nis = 0;
      for (int c = 0; c < 12; c++) begin
        req_re = ~req_busy; req_addr = {16'h0200, 16'h0100};
        mem_ready = mem_re; mem_addr_out = mem_raddr; mem_data_out = 16'(c);
        tick();
        if (mem_re) begin
          check($sformatf("rr_issue%0d", nis), mem_raddr, (nis % 2 == 0) ? 16'h0100 : 16'h0200);
          nis++;
        end
      end
      check("rr_issue_count_ge6", 64'(nis >= 6), 64'd1);
    end

    // Outstanding cap on a 3-requester, MAX_OUT=2 instance.
    do_reset();
    begin
      int npulse = 0;
      c_req_re = 3'b111; c_req_addr = {16'h00C0, 16'h00B0, 16'h00A0};
      tick();
      c_req_re = '0;
      repeat (5) begin tick(); npulse += int'(c_mre); end
      check("cap_pulses", npulse, 2);
      check("cap_busy", c_busy, 3'b111);
      c_rdy = 1'b1; c_maddr = 16'h00A0; c_mdata = 16'h0AAA;
      tick();
      c_rdy = 1'b0;
      check("cap_resp", {c_mre, c_rv, c_rdata}, {1'b0, 3'b001, 16'h0AAA});
      tick();
      check("cap_third_issue", {c_mre, c_raddr}, {1'b1, 16'h00C0});
    end

    // Asynchronous reset with two reads in flight.
    do_reset();
    req_re = 2'b11; req_addr = {16'h0022, 16'h0011};
    tick();
    req_re = '0;
    tick();
    tick();
    check("pre_rst_busy_mre", {req_busy, mem_re}, {2'b11, 1'b1});
    #2 rst_n = 1'b0;
    #1 check("async_rst_outputs", {req_busy, mem_re, mem_raddr, rsp_valid, rsp_data}, 64'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    mem_ready = 1'b1; mem_addr_out = 16'h0011; mem_data_out = 16'h9999;
    tick();
    mem_ready = 1'b0;
    check("post_rst_resp", {rsp_valid, u_dut.out_cnt_q}, {2'b00, 4'd0});

    // Randomized run against the reference model.
    do_reset();
    model_reset();
    memq.delete();
    for (int c = 0; c < 300; c++) begin
      logic [1:0]  rq;
      logic [15:0] a0, a1, ma, md;
      logic        rdy;
      rq = 2'($urandom);
      a0 = 16'h0010 * 16'($urandom_range(1, 3));
      a1 = 16'h0010 * 16'($urandom_range(1, 3));
      md = 16'($urandom);
      rdy = 1'b0; ma = 16'h0;
      if (memq.size() > 0 && $urandom_range(0, 1) == 1) begin
        rdy = 1'b1; ma = memq.pop_front();
      end else if ($urandom_range(0, 19) == 0) begin
        rdy = 1'b1; ma = 16'hFFFF;
      end
      req_re = rq; req_addr = {a1, a0};
      mem_ready = rdy; mem_addr_out = ma; mem_data_out = md;
      model_step(rq, a0, a1, rdy, ma, md);
      tick();
      check($sformatf("rand%0d", c),
            {u_dut.out_cnt_q, req_busy, mem_re, mem_raddr, rsp_valid, rsp_data},
            {4'(m_cnt), (m_st[1] != 0), (m_st[0] != 0), m_re, m_raddr, m_rv, m_rdata});
      if (m_re) memq.push_back(m_raddr);
    end
    clr_inputs();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
